riscv_insn_encode_writer: RTL
=============================

// Module: riscv_insn_encode_writer
// PURPOSE
//  Inverse of instruction field decode: accepts RISC-V RV32I instruction fields plus a full 32-bit immediate value
//  over a valid/ready stream, packs them into a 32-bit instruction word by format (R/I/S/B/U/J derived from opcode),
//  checks legality, and writes legal words sequentially into instruction memory. Used by the loader/self-test path
//  to build programs in IMEM without an external assembler.
// PARAMETERS
//  ADDR_W     32    width of mem_addr (byte address)
//  BASE_ADDR  0     byte address of first word written; must be 4-byte aligned
//  MAX_WORDS  1024  words writable before full; >=1
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        reset, synchronous, active-high
//  in_valid    in   1        field bundle valid
//  in_ready    out  1        bundle accepted when in_valid & in_ready
//  in_opcode   in   7        insn[6:0]
//  in_rd       in   5        destination register
//  in_funct3   in   3        funct3
//  in_rs1      in   5        source register 1
//  in_rs2      in   5        source register 2
//  in_funct7   in   7        funct7 (R-type only; ignored otherwise)
//  in_imm      in   32       immediate as signed byte value (U: full value, low 12 bits must be 0)
//  mem_we      out  1        write request
//  mem_addr    out  ADDR_W   write byte address
//  mem_wdata   out  32       encoded instruction word
//  mem_ready   in   1        memory accepts write when mem_we & mem_ready (write_fire)
//  rewind      in   1        restart at BASE_ADDR, clear count, drop pending word
//  full        out  1        word_count == MAX_WORDS
//  word_count  out  $clog2(MAX_WORDS+1)  words written since reset/rewind
//  err_valid   out  1        one-cycle pulse: accepted bundle rejected
//  err_code    out  2        01 unknown opcode, 10 imm out of range, 11 misaligned B/J offset; held until next error
// BEHAVIOUR
//  - Reset: in_ready=0 during rst, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, word_count=0, full=0, err_valid=0, err_code=0.
//  - Formats: 0110111/0010111 U; 1101111 J; 1100111,0000011,0010011,1110011 I; 0100011 S; 1100011 B; 0110011 R.
//    Any other opcode -> err 01. funct3/funct7 values otherwise not checked.
//  - Packing: I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op};
//    B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op};
//    J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}; R {f7,rs2,rs1,f3,rd,op}.
//  - Range: I/S imm in [-2048,2047]; B in [-4096,4094]; J in [-2^20,2^20-2]; U imm[11:0]==0 else err 10.
//    B/J with imm[0]=1 -> err 11 (checked after range; range wins if both).
//  - Pipeline: one encode register (E). Bundle accepted cycle N -> legal: mem_we=1 from N+1 with addr/wdata stable
//    until write_fire; illegal: err_valid=1 in N+1 only, E not loaded, addr/count unchanged.
//  - in_ready = !rst & !rewind & (E empty ? word_count<MAX_WORDS : write_fire & word_count+1<MAX_WORDS).
//    Combinational path mem_ready->in_ready is intentional (back-to-back one word/cycle at full throughput).
//  - write_fire: mem_addr += 4 (wraps modulo 2^ADDR_W), word_count += 1; E refilled same cycle if new bundle accepted.
//  - full asserts the cycle after the MAX_WORDS-th write_fire; stays until rewind/rst.
//  - rewind: next cycle mem_we=0, mem_addr=BASE_ADDR, word_count=0, full=0; pending E word discarded even if
//    mem_ready high that cycle (no write counted); no bundle accepted while rewind=1; err_code kept.
//  - rst mid-write: same as rewind plus err_code cleared.
// STRUCTURE
//  - riscv_pkg: opcode localparams, fmt_e {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_BAD}, err_e codes.
//  - Sub-module riscv_insn_encode: purely combinational fields+imm -> {word, fmt, err_code}; top holds E register,
//    address counter, word counter, handshake and error pulse.
// TESTING
//  - ADDI x1,x0,5 (op 0010011,f3 0,rd1,rs1 0,imm 5), mem_ready=1 -> mem_we N+1, addr BASE, wdata 0x00500093, count 1.
//  - SW x2,8(x1) then BEQ x0,x0,-4 back-to-back -> 0x0020A423 @BASE, 0xFE000EE3 @BASE+4, in_ready high throughout.
//  - ADDI imm=2048 -> err_valid pulse, err_code 10; opcode 0x7F -> err 01; JAL imm=3 -> err 11; addr/count unchanged.
//  - mem_ready low 3 cycles with E full -> mem_we/addr/wdata stable, in_ready 0; mem_ready high -> write, accept resumes.
//  - MAX_WORDS=2: three legal bundles -> two writes, full=1, in_ready 0, third bundle never accepted.
//  - rewind while mem_we=1 & mem_ready=1 -> no count increment, next cycle addr BASE, count 0, full 0, mem_we 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I instruction encoder/writer.
//   - Opcode constants for the formats the encoder understands
//   - fmt_e : instruction format derived from the opcode
//   - err_e : rejection codes reported on err_code
//   - opcode_fmt()   : opcode -> format lookup
//   - imm_in_range() : signed inclusive range test on a 32-bit immediate
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_RANGE  = 2'b10,
        ERR_ALIGN  = 2'b11
    } err_e;

    function automatic fmt_e opcode_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_LUI, OP_AUIPC:                     f = FMT_U;
            OP_JAL:                               f = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:  f = FMT_I;
            OP_STORE:                             f = FMT_S;
            OP_BRANCH:                            f = FMT_B;
            OP_REG:                               f = FMT_R;
            default:                              f = FMT_BAD;
        endcase
        return f;
    endfunction

    // Inclusive signed range test; the immediate is a two's-complement byte value.
    function automatic logic imm_in_range(input logic [31:0] imm, input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/riscv_insn_encode.sv
// Purely combinational RV32I field packer.
//   opcode/rd/funct3/rs1/rs2/funct7 : instruction fields
//   imm    : full 32-bit immediate (signed byte value; U-type carries the whole value)
//   word   : packed instruction word (don't-care when err != ERR_NONE)
//   fmt    : format derived from opcode
//   err    : ERR_NONE when the bundle is encodable, otherwise the rejection reason
module riscv_insn_encode
    import riscv_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output fmt_e        fmt,
    output err_e        err
);

    always_comb begin
        fmt  = opcode_fmt(opcode);
        word = '0;
        err  = ERR_NONE;
        case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                if (!imm_in_range(imm, -2048, 2047)) err = ERR_RANGE;
            end
            FMT_S: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                if (!imm_in_range(imm, -2048, 2047)) err = ERR_RANGE;
            end
            FMT_B: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                // Range is reported in preference to misalignment.
                if (!imm_in_range(imm, -4096, 4094)) err = ERR_RANGE;
                else if (imm[0])                     err = ERR_ALIGN;
            end
            FMT_U: begin
                word = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'd0) err = ERR_RANGE;
            end
            FMT_J: begin
                word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!imm_in_range(imm, -(1 << 20), (1 << 20) - 2)) err = ERR_RANGE;
                else if (imm[0])                                   err = ERR_ALIGN;
            end
            default: err = ERR_OPCODE;
        endcase
    end

endmodule

// File: rtl/riscv_insn_encode_writer.sv
// Accepts RV32I field bundles on a valid/ready stream, encodes them and writes
// legal words sequentially into instruction memory starting at BASE_ADDR.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : bundle handshake; in_* carry the fields and immediate
//   mem_we/mem_addr/mem_wdata: write request, held until mem_ready (write_fire)
//   rewind                   : restart at BASE_ADDR, clear count, drop pending word
//   full, word_count         : words written since reset/rewind
//   err_valid, err_code      : one-cycle reject pulse, code held until next reject
module riscv_insn_encode_writer
    import riscv_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                MAX_WORDS = 1024,
    localparam int               CW        = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              rewind,
    output logic              full,
    output logic [CW-1:0]     word_count,
    output logic              err_valid,
    output logic [1:0]        err_code
);

    localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_WORDS);

    logic              e_valid_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [CW-1:0]     count_reg;
    logic              err_valid_reg;
    err_e              err_code_reg;

    logic [31:0] enc_word;
    fmt_e        enc_fmt;
    err_e        enc_err;

    riscv_insn_encode u_encode (
        .opcode (in_opcode),
        .rd     (in_rd),
        .funct3 (in_funct3),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct7 (in_funct7),
        .imm    (in_imm),
        .word   (enc_word),
        .fmt    (enc_fmt),
        .err    (enc_err)
    );

    logic        write_fire;
    logic        accept;
    logic        legal;
    logic [CW:0] count_ext;

    assign count_ext  = {1'b0, count_reg};
    assign write_fire = e_valid_reg & mem_ready;
    assign legal      = (enc_err == ERR_NONE) && (enc_fmt != FMT_BAD);

    // A new bundle may enter when E is free, or when E drains this very cycle;
    // in the latter case the draining word already consumes one slot of capacity.
    // The mem_ready -> in_ready path is combinational so the stream runs at one word per cycle.
    assign in_ready = !rst && !rewind &&
                      (e_valid_reg ? (write_fire && ((count_ext + (CW + 1)'(1)) < MAX_W))
                                   : (count_ext < MAX_W));
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid_reg   <= 1'b0;
            addr_reg      <= BASE_ADDR;
            wdata_reg     <= '0;
            count_reg     <= '0;
            err_valid_reg <= 1'b0;
            err_code_reg  <= ERR_NONE;
        end else if (rewind) begin
            // Pending word is dropped without counting, even if mem_ready is high now.
            e_valid_reg   <= 1'b0;
            addr_reg      <= BASE_ADDR;
            count_reg     <= '0;
            err_valid_reg <= 1'b0;
        end else begin
            err_valid_reg <= accept & !legal;
            if (accept && !legal) err_code_reg <= enc_err;

            if (write_fire) begin
                addr_reg  <= addr_reg + ADDR_W'(4);
                count_reg <= count_reg + CW'(1);
            end

            if (accept && legal) begin
                e_valid_reg <= 1'b1;
                wdata_reg   <= enc_word;
            end else if (write_fire) begin
                e_valid_reg <= 1'b0;
            end
        end
    end

    assign mem_we     = e_valid_reg;
    assign mem_addr   = addr_reg;
    assign mem_wdata  = wdata_reg;
    assign word_count = count_reg;
    assign full       = (count_ext == MAX_W);
    assign err_valid  = err_valid_reg;
    assign err_code   = err_code_reg;

endmodule
